// File: rtl/rx_eyeq_pkg.sv
// rx_eyeq_pkg: shared types for the multi-lane RX eye-quality handshake controller.
package rx_eyeq_pkg;
    localparam int EYEQMODE_W  = 4;
    localparam int POWERDOWN_W = 2;

    typedef enum logic [EYEQMODE_W-1:0] {
        UNKNOWN_MODE    = 4'bxxxx,
        STARTUP_NRZ_DDR = 4'h1,
        STARTUP_NRZ_SDR = 4'h2,
        TRAIN_NRZ       = 4'h3,
        TRAIN_PAM4      = 4'h4,
        TRACK           = 4'h5
    } eyeqmode_t;

    typedef enum logic [POWERDOWN_W-1:0] {
        POWERDOWN_NORMAL = 2'b00,
        POWERDOWN_IDLE   = 2'b01,
        POWERDOWN_SLEEP  = 2'b11,
        POWERDOWN_COMA   = 2'b10
    } powerdown_t;

    typedef enum logic [2:0] {IDLE, ARM, REQ, REL, FIN} state_t;
endpackage

// File: rtl/rx_eyeq_lane.sv
// rx_eyeq_lane: per-lane done-edge tracking and one-shot result capture.
module rx_eyeq_lane #(
    parameter int EYEQ_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic              i_req,
    input  logic              i_done,
    input  logic [EYEQ_W-1:0] i_eyeq,
    output logic              o_cap,
    output logic [EYEQ_W-1:0] o_result
);
    logic              r_done_d;
    logic              r_cap;
    logic [EYEQ_W-1:0] r_result;

    // The PHY result is only stable one cycle after done rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_d <= 1'b0;
            r_cap    <= 1'b0;
            r_result <= '0;
        end else begin
            r_done_d <= i_done;
            if (i_clr) begin
                r_cap    <= 1'b0;
                r_result <= '0;
            end else if (i_en && i_done && r_done_d && !r_cap) begin
                r_cap    <= 1'b1;
                r_result <= i_eyeq;
            end
        end
    end

    assign o_cap    = r_cap;
    assign o_result = r_result;

    a_no_req_rise_on_done: assert property (@(posedge clk) disable iff (!rst_n)
        !($rose(i_req) && i_done));
endmodule

// File: rtl/rx_eyeq_ctrl.sv
// rx_eyeq_ctrl: MAC-side multi-lane EyeQ 4-way handshake controller with
// lane masking, powerdown gating, timeout and worst-lane reduction.
module rx_eyeq_ctrl
    import rx_eyeq_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int EYEQ_W    = 8,
    parameter int TMO_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [3:0]                    start_mode,
    input  logic [NUM_LANES-1:0]          lane_mask,
    input  logic [TMO_W-1:0]              tmo_limit,
    output logic                          busy,
    output logic                          done,
    output logic                          tmo_err,
    output logic [NUM_LANES-1:0]          skip_mask,
    output logic [NUM_LANES*EYEQ_W-1:0]   result,
    output logic [EYEQ_W-1:0]             result_min,
    output logic [NUM_LANES-1:0]          rxeyeqreq,
    output logic [3:0]                    rxeyeqmode,
    input  logic [NUM_LANES-1:0]          rxeyeqdone,
    input  logic [NUM_LANES*EYEQ_W-1:0]   rxeyeq,
    input  logic [NUM_LANES*2-1:0]        rxpdwn
);
    state_t                 r_state, w_next;
    logic [NUM_LANES-1:0]   r_act, r_req, r_skip;
    logic [NUM_LANES-1:0]   w_norm, w_act, w_cap;
    logic [TMO_W-1:0]       r_limit, r_cnt;
    logic [3:0]             r_mode;
    logic                   r_busy, r_done, r_tmo;
    logic [EYEQ_W-1:0]      r_min, w_min;
    logic [EYEQ_W-1:0]      w_res [NUM_LANES];
    logic                   w_accept, w_tmo, w_quiet, w_allcap, w_phase;

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            assign w_norm[i] = rxpdwn[i*POWERDOWN_W +: POWERDOWN_W] == POWERDOWN_NORMAL;
            rx_eyeq_lane #(.EYEQ_W(EYEQ_W)) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_clr    (w_accept && w_act[i]),
                .i_en     (r_state == REQ && r_act[i]),
                .i_req    (r_req[i]),
                .i_done   (rxeyeqdone[i]),
                .i_eyeq   (rxeyeq[i*EYEQ_W +: EYEQ_W]),
                .o_cap    (w_cap[i]),
                .o_result (w_res[i])
            );
            assign result[i*EYEQ_W +: EYEQ_W] = w_res[i];
        end
    endgenerate

    assign w_act    = lane_mask & w_norm;
    assign w_accept = start && !r_busy;
    assign w_quiet  = (rxeyeqdone & r_act) == '0;
    assign w_allcap = (w_cap & r_act) == r_act;
    assign w_phase  = r_state == ARM || r_state == REQ || r_state == REL;
    assign w_tmo    = w_phase && r_limit != '0 && r_cnt == r_limit;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, FIN: w_next = w_accept ? (w_act == '0 ? FIN : ARM) : IDLE;
            ARM:       w_next = w_tmo ? REL : (w_quiet ? REQ : ARM);
            REQ:       w_next = (w_tmo || w_allcap) ? REL : REQ;
            REL:       w_next = (w_tmo || w_quiet) ? FIN : REL;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        w_min = '1;
        for (int k = 0; k < NUM_LANES; k++)
            if (w_cap[k] && r_act[k] && w_res[k] < w_min) w_min = w_res[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act   <= '0;
            r_req   <= '0;
            r_skip  <= '0;
            r_limit <= '0;
            r_cnt   <= '0;
            r_mode  <= UNKNOWN_MODE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tmo   <= 1'b0;
            r_min   <= '1;
        end else begin
            r_done <= w_next == FIN;
            // Counter restarts on every phase change and saturates.
            if (w_next != r_state)  r_cnt <= '0;
            else if (r_cnt != '1)   r_cnt <= r_cnt + TMO_W'(1);
            if (w_accept) begin
                r_act   <= w_act;
                r_skip  <= lane_mask & ~w_act;
                r_limit <= tmo_limit;
                r_tmo   <= 1'b0;
            end else if (w_tmo) begin
                r_tmo   <= 1'b1;
            end
            if (w_next == FIN) begin
                r_busy <= 1'b0;
                r_mode <= UNKNOWN_MODE;
                r_min  <= w_accept ? '1 : w_min;
            end else if (w_accept) begin
                r_busy <= 1'b1;
                r_mode <= start_mode;
            end
            if (r_state == ARM && w_next == REQ)      r_req <= r_act;
            else if (r_state == REQ && w_next != REQ) r_req <= '0;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign tmo_err    = r_tmo;
    assign skip_mask  = r_skip;
    assign result_min = r_min;
    assign rxeyeqreq  = r_req;
    assign rxeyeqmode = r_mode;
endmodule

// File: doc/rx_eyeq_ctrl.md
Name: rx_eyeq_ctrl

Overview:
- Multi-lane MAC-side controller for the PHY RX eye-quality (EyeQ) 4-way handshake (rxeyeqreq/rxeyeqdone).
- Generalises the single-lane handshake to NUM_LANES lanes with per-lane masking, powerdown gating, result capture, worst-lane reduction and timeout.
- Sits between link-training firmware and the per-lane PHY RX interfaces.

Parameters:
- NUM_LANES, 4: number of RX lanes (1..16).
- EYEQ_W, 8: width of each per-lane unsigned eye-quality result.
- TMO_W, 16: timeout counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; ignored unless busy=0.
- start_mode  in  4  eyeqmode_t applied for this operation.
- lane_mask  in  NUM_LANES  lanes requested; sampled with start.
- tmo_limit  in  TMO_W  cycles allowed per phase; 0 disables the timeout.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse at completion.
- tmo_err  out  1  sticky; set on timeout, cleared by the next accepted start.
- skip_mask  out  NUM_LANES  lanes excluded because rxpdwn != POWERDOWN_NORMAL at start.
- result  out  NUM_LANES*EYEQ_W  captured rxeyeq per lane; lane i at bits [i*EYEQ_W +: EYEQ_W].
- result_min  out  EYEQ_W  minimum result over the active lanes.
- rxeyeqreq  out  NUM_LANES  per-lane request.
- rxeyeqmode  out  4  shared mode to the PHY.
- rxeyeqdone  in  NUM_LANES  per-lane done.
- rxeyeq  in  NUM_LANES*EYEQ_W  per-lane result.
- rxpdwn  in  NUM_LANES*2  per-lane powerdown_t.

Behaviour:
- Reset values:
  - busy, done, tmo_err, rxeyeqreq, skip_mask, result = 0.
  - result_min = all-ones.
  - rxeyeqmode = UNKNOWN_MODE.
  - FSM = IDLE.
  - Reset mid-operation forces all reset values immediately (asynchronous).
- Active set: act = lane_mask & (rxpdwn==NORMAL per lane), computed at start.
  - skip_mask = lane_mask & ~act.
  - If act == 0: done pulses the next cycle, busy never rises, result_min = all-ones.
- FSM states IDLE, ARM, REQ, REL, FIN.
- IDLE:
  - On start with act != 0: latch act, mode and limit; drive rxeyeqmode = start_mode; set busy; clear tmo_err and the result of each act lane.
  - Go to ARM.
- ARM:
  - Wait until rxeyeqdone & act == 0; a 4-way rule forbids raising req while done is high.
  - Then set rxeyeqreq = act (registered) and go to REQ.
- REQ:
  - Lane i captures rxeyeq[i] on the second consecutive cycle rxeyeqdone[i] is high, i.e. one cycle after its rise, which is where the PHY guarantees stability.
  - Capture occurs exactly once per operation.
  - When all act lanes are captured, deassert rxeyeqreq for all lanes together and go to REL.
  - Lanes whose done rises early are held; req never drops before its done is high.
- REL:
  - Wait for rxeyeqdone & act == 0.
  - Then go to FIN.
  - rxeyeqmode stays constant from ARM until FIN.
- FIN:
  - done = 1 for one cycle, busy = 0, rxeyeqmode = UNKNOWN_MODE.
  - result_min = registered minimum over captured act lanes; ties are irrelevant.
  - Go to IDLE.
- Timeout:
  - A per-phase counter resets on entry to ARM, REQ and REL and saturates at its maximum.
  - Trigger condition: tmo_limit != 0 and count == tmo_limit.
  - In ARM or REQ: set tmo_err, deassert all rxeyeqreq, go to REL; uncaptured lanes keep result 0.
  - In REL: set tmo_err and go to FIN. Done still pulses.
- start while busy: ignored, with no side effects.
- rxpdwn leaving NORMAL mid-operation does not affect the handshake; it is flagged only via timeout.
- result_min width is EYEQ_W, unsigned compare; the reduction is a combinational tree registered once.

Decomposition:
- Package rx_eyeq_pkg holds:
  - eyeqmode_t (4-bit, incl. UNKNOWN_MODE = 'x) and powerdown_t (2-bit: NORMAL 00, IDLE 01, SLEEP 11, COMA 10);
  - EYEQMODE_W = 4, POWERDOWN_W = 2;
  - the FSM state enum.
- One sub-module, rx_eyeq_lane: per-lane capture flag, done-edge detection and result register, instantiated NUM_LANES times by generate.
- The FSM and min reduction live in the top.
- The 4-way SVA properties are bound per lane.

Test Plan:
- All lanes normal (NUM_LANES=4, mask 4'hF, mode STARTUP_NRZ_DDR): lanes raise done after 3/5/7/9 cycles with rxeyeq 10/20/5/30 → req falls together after the last capture; result = {30,5,20,10}; result_min = 5; done pulses once; tmo_err = 0.
- Lane 2 in POWERDOWN_COMA, mask 4'hF → skip_mask = 4'b0100; rxeyeqreq[2] never rises; result_min taken over lanes 0, 1 and 3 only.
- rxeyeqdone[1] still high at start → req is held in ARM until it falls, then rises; no $rose(req) while done is high.
- tmo_limit = 20, lane 3 never asserts done → at REQ cycle 20 all req drop; tmo_err = 1; result[3] = 0; done pulses after the other lanes' done fall.
- rxeyeq changes in the same cycle done rises → value from the next cycle is captured; start pulsed while busy is ignored; rst_n low mid-REQ → all req = 0 and busy = 0 asynchronously.
- mask = 0 or all lanes asleep → done is pulsed the cycle after start; no req toggles; result_min = 8'hFF.
